pe_accumulator: RTL and testbench

Downstream reduction stage for the processing-element (PE) array. It consumes the 16-bit unsigned product stream of one PE column and sums a programmed number of products into one dot-product result. Completed results are pushed into a 2-entry output buffer and drained over a valid/ready interface toward writeback. The PE has no backpressure, so this block never stalls its input. Lost results are flagged instead.

---
 rtl/pe_acc_pkg.sv | 20 ++
 rtl/pe_result_fifo.sv | 51 +++++
 rtl/pe_accumulator.sv | 128 ++++++++++++
 tb/tb_pe_accumulator.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pe_acc_pkg.sv
// Shared types and default widths for the PE column reduction stage.
package pe_acc_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    localparam int DEF_PROD_W     = 16;
    localparam int DEF_ACC_W      = 24;
    localparam int DEF_CNT_W      = 8;
    localparam int DEF_FIFO_DEPTH = 2;

    // Buffer entry layout at default widths; the top re-declares it for its own ACC_W.
    typedef struct packed {
        logic                 overflow;
        logic [DEF_ACC_W-1:0] sum;
    } result_t;

endpackage

// File: rtl/pe_result_fifo.sv
// Small synchronous result buffer; a push into a full buffer succeeds only
// when the head is popped in the same cycle.
module pe_result_fifo #(
    parameter int W     = 25,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    always_comb begin
        empty    = (count == '0);
        full     = (count == FULL_CNT);
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        pop_data = empty ? '0 : mem[rd_ptr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
        end
    end

endmodule

// File: rtl/pe_accumulator.sv
// Sums a programmed number of PE products per vector with saturation and
// queues each completed dot product for a valid/ready consumer.
module pe_accumulator
    import pe_acc_pkg::*;
#(
    parameter int PROD_W     = DEF_PROD_W,
    parameter int ACC_W      = DEF_ACC_W,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              start,
    input  logic [CNT_W-1:0]  len_cfg,
    input  logic [PROD_W-1:0] prod_in,
    input  logic              prod_valid,
    output logic              busy,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_overflow,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              drop_err
);

    typedef struct packed {
        logic             overflow;
        logic [ACC_W-1:0] sum;
    } entry_t;

    // MSB of the result flags overflow; the low ACC_W bits are already clamped.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [PROD_W-1:0] b);
        logic [ACC_W:0] wide;
        wide = {1'b0, a} + (ACC_W + 1)'(b);
        if (wide[ACC_W]) return {1'b1, {ACC_W{1'b1}}};
        return wide;
    endfunction

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic             sat;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] len;
    logic             accept;
    logic             last;
    logic [ACC_W:0]   add_res;
    entry_t           push_entry;
    entry_t           head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             drop;

    always_comb begin
        accept              = (state == ACCUM) && enable && prod_valid;
        last                = accept && (cnt == len);
        add_res             = sat_add(acc, prod_in);
        push_entry.overflow = sat | add_res[ACC_W];
        push_entry.sum      = add_res[ACC_W-1:0];
        drop                = last && fifo_full && !(out_ready && !fifo_empty);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            sat   <= 1'b0;
            cnt   <= '0;
            len   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable && start) begin
                        state <= ACCUM;
                        acc   <= '0;
                        sat   <= 1'b0;
                        cnt   <= '0;
                        len   <= len_cfg;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc <= add_res[ACC_W-1:0];
                        sat <= sat | add_res[ACC_W];
                        cnt <= cnt + CNT_W'(1);
                        // A start on the final product chains straight into the next vector.
                        if (last) begin
                            if (start) begin
                                acc <= '0;
                                sat <= 1'b0;
                                cnt <= '0;
                                len <= len_cfg;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       drop_err <= 1'b0;
        else if (drop) drop_err <= 1'b1;
    end

    pe_result_fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (last),
        .push_data (push_entry),
        .pop       (out_ready),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign busy         = (state == ACCUM);
    assign out_valid    = !fifo_empty;
    assign out_sum      = head.sum;
    assign out_overflow = head.overflow;

endmodule

// File: tb/tb_pe_accumulator.sv
// Directed bench for pe_accumulator: a default-width instance plus a 16-bit
// accumulator instance sharing the same stimulus for the saturation case.
module tb_pe_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        start;
    logic [7:0]  len_cfg;
    logic [15:0] prod_in;
    logic        prod_valid;
    logic        out_ready;

    logic        busy;
    logic [23:0] out_sum;
    logic        out_overflow;
    logic        out_valid;
    logic        drop_err;

    logic        busy_s;
    logic [15:0] out_sum_s;
    logic        out_overflow_s;
    logic        out_valid_s;
    logic        drop_err_s;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pe_accumulator dut (
        .clk(clk), .rst(rst), .enable(enable), .start(start), .len_cfg(len_cfg),
        .prod_in(prod_in), .prod_valid(prod_valid), .busy(busy), .out_sum(out_sum),
        .out_overflow(out_overflow), .out_valid(out_valid), .out_ready(out_ready),
        .drop_err(drop_err)
    );

    pe_accumulator #(.ACC_W(16)) dut_s (
        .clk(clk), .rst(rst), .enable(enable), .start(start), .len_cfg(len_cfg),
        .prod_in(prod_in), .prod_valid(prod_valid), .busy(busy_s), .out_sum(out_sum_s),
        .out_overflow(out_overflow_s), .out_valid(out_valid_s), .out_ready(out_ready),
        .drop_err(drop_err_s)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] len);
        start   = 1'b1;
        len_cfg = len;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input logic [15:0] p);
        prod_in    = p;
        prod_valid = 1'b1;
        tick();
        prod_valid = 1'b0;
    endtask

    task automatic drain_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; start = 1'b0; len_cfg = '0;
        prod_in = '0; prod_valid = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (out_sum !== 24'd0) begin failures++; $display("FAIL reset_sum: got %0d expected 0", out_sum); end
        checks++; if (out_overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b expected 0", out_overflow); end
        checks++; if (drop_err !== 1'b0) begin failures++; $display("FAIL reset_drop: got %b expected 0", drop_err); end
        rst    = 1'b0;
        enable = 1'b1;
        tick();
    endtask

    task automatic test_basic_sum();
        do_start(8'd3);
        feed(16'd10);
        feed(16'd20);
        feed(16'd30);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid: got %b expected 0", out_valid); end
        feed(16'd40);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid: got %b expected 1", out_valid); end
        checks++; if (out_sum !== 24'd100) begin failures++; $display("FAIL basic_sum: got %0d expected 100", out_sum); end
        checks++; if (out_overflow !== 1'b0) begin failures++; $display("FAIL basic_ovf: got %b expected 0", out_overflow); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy: got %b expected 0", busy); end
        drain_one();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_drained: got %b expected 0", out_valid); end
    endtask

    task automatic test_gaps_enable();
        prod_in = 16'd99; prod_valid = 1'b1;
        tick();
        prod_valid = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_prod_busy: got %b expected 0", busy); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL idle_prod_valid: got %b expected 0", out_valid); end
        do_start(8'd3);
        feed(16'd10);
        tick();
        feed(16'd20);
        enable = 1'b0; prod_in = 16'd500; prod_valid = 1'b1;
        repeat (3) tick();
        prod_valid = 1'b0; enable = 1'b1;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL gap_busy: got %b expected 1", busy); end
        feed(16'd30);
        tick();
        feed(16'd40);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL gap_valid: got %b expected 1", out_valid); end
        checks++; if (out_sum !== 24'd100) begin failures++; $display("FAIL gap_sum: got %0d expected 100", out_sum); end
        drain_one();
    endtask

    task automatic test_saturation();
        do_start(8'd1);
        feed(16'd40000);
        feed(16'd40000);
        checks++; if (out_sum_s !== 16'd65535) begin failures++; $display("FAIL sat_sum: got %0d expected 65535", out_sum_s); end
        checks++; if (out_overflow_s !== 1'b1) begin failures++; $display("FAIL sat_ovf: got %b expected 1", out_overflow_s); end
        checks++; if (out_sum !== 24'd80000) begin failures++; $display("FAIL wide_sum: got %0d expected 80000", out_sum); end
        checks++; if (out_overflow !== 1'b0) begin failures++; $display("FAIL wide_ovf: got %b expected 0", out_overflow); end
        drain_one();
        do_start(8'd1);
        feed(16'd1);
        feed(16'd2);
        checks++; if (out_sum_s !== 16'd3) begin failures++; $display("FAIL sat_next_sum: got %0d expected 3", out_sum_s); end
        checks++; if (out_overflow_s !== 1'b0) begin failures++; $display("FAIL sat_next_ovf: got %b expected 0", out_overflow_s); end
        drain_one();
    endtask

    task automatic test_max_length();
        do_start(8'd255);
        for (int i = 0; i < 255; i++) feed(16'd65025);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL max_early_valid: got %b expected 0", out_valid); end
        feed(16'd65025);
        checks++; if (out_sum !== 24'd16646400) begin failures++; $display("FAIL max_sum: got %0d expected 16646400", out_sum); end
        checks++; if (out_overflow !== 1'b0) begin failures++; $display("FAIL max_ovf: got %b expected 0", out_overflow); end
        drain_one();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        do_start(8'd0); feed(16'd5);
        do_start(8'd0); feed(16'd6);
        checks++; if (drop_err !== 1'b0) begin failures++; $display("FAIL bp_drop_early: got %b expected 0", drop_err); end
        do_start(8'd0); feed(16'd7);
        checks++; if (drop_err !== 1'b1) begin failures++; $display("FAIL bp_drop: got %b expected 1", drop_err); end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid: got %b expected 1", out_valid); end
        tick();
        checks++; if (out_sum !== 24'd5) begin failures++; $display("FAIL bp_head_stable: got %0d expected 5", out_sum); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_sum !== 24'd6) begin failures++; $display("FAIL bp_second: got %0d expected 6", out_sum); end
        tick();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_empty_valid: got %b expected 0", out_valid); end
        checks++; if (out_sum !== 24'd0) begin failures++; $display("FAIL bp_empty_sum: got %0d expected 0", out_sum); end
        checks++; if (drop_err !== 1'b1) begin failures++; $display("FAIL bp_drop_sticky: got %b expected 1", drop_err); end
    endtask

    task automatic test_back_to_back();
        do_start(8'd1);
        feed(16'd3);
        prod_in = 16'd4; prod_valid = 1'b1; start = 1'b1; len_cfg = 8'd2;
        tick();
        prod_valid = 1'b0; start = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy: got %b expected 1", busy); end
        checks++; if (out_sum !== 24'd7) begin failures++; $display("FAIL b2b_first: got %0d expected 7", out_sum); end
        feed(16'd100);
        feed(16'd200);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_mid_busy: got %b expected 1", busy); end
        feed(16'd300);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_done_busy: got %b expected 0", busy); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_sum !== 24'd600) begin failures++; $display("FAIL b2b_second: got %0d expected 600", out_sum); end
        tick();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_empty: got %b expected 0", out_valid); end
    endtask

    task automatic test_reset_mid_vector();
        do_start(8'd0);
        feed(16'd9);
        do_start(8'd2);
        feed(16'd50);
        feed(16'd60);
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
        checks++; if (drop_err !== 1'b0) begin failures++; $display("FAIL rst_drop: got %b expected 0", drop_err); end
        checks++; if (out_sum !== 24'd0) begin failures++; $display("FAIL rst_sum: got %0d expected 0", out_sum); end
        tick();
        rst = 1'b0;
        tick();
        do_start(8'd1);
        feed(16'd7);
        feed(16'd8);
        checks++; if (out_sum !== 24'd15) begin failures++; $display("FAIL rst_next_sum: got %0d expected 15", out_sum); end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rst_next_valid: got %b expected 1", out_valid); end
        checks++; if (out_overflow !== 1'b0) begin failures++; $display("FAIL rst_next_ovf: got %b expected 0", out_overflow); end
        drain_one();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic_sum();
        test_gaps_enable();
        test_saturation();
        test_max_length();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_vector();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
